// File: rtl/instruction_fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage:
// fetch FSM states, word sizes and the NOP encoding.
package instruction_fetch_stage_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DRAIN
   } state_t;

   function automatic logic [XLEN-1:0] align(
      input logic [XLEN-1:0] a
   );
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch stage bus: instruction memory port,
// redirect input and IF/ID handoff to decode.
interface instruction_fetch_stage_if;
   import instruction_fetch_stage_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [ILEN-1:0] id_instruction;

   modport master (
      output imem_req_valid,
      output imem_addr,
      output id_valid,
      output id_pc,
      output id_instruction,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      input  redirect_valid,
      input  redirect_pc,
      input  id_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      input  id_valid,
      input  id_pc,
      input  id_instruction,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      output redirect_valid,
      output redirect_pc,
      output id_ready
   );

endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: PC register, single-outstanding
// request FSM and the IF/ID pipeline register.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input logic                    clk,
   input logic                    reset,
   instruction_fetch_stage_if.master bus
);

   state_t          state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] req_pc, req_pc_n;
   logic            id_valid, id_valid_n;
   logic [XLEN-1:0] id_pc, id_pc_n;
   logic [ILEN-1:0] id_instr, id_instr_n;
   logic            req_valid;

   // Only issue when the IF/ID slot is free or being drained.
   assign req_valid = !reset
                    && (state == S_FETCH)
                    && !bus.redirect_valid
                    && (!id_valid || bus.id_ready);

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = pc;
   assign bus.id_valid       = id_valid;
   assign bus.id_pc          = id_pc;
   assign bus.id_instruction = id_instr;

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_pc_n   = req_pc;
      id_valid_n = id_valid;
      id_pc_n    = id_pc;
      id_instr_n = id_instr;
      if (id_valid && bus.id_ready)
         id_valid_n = 1'b0;
      if (bus.redirect_valid) begin
         pc_n       = align(bus.redirect_pc);
         id_valid_n = 1'b0;
         // An outstanding response must be swallowed.
         if (state != S_FETCH)
            state_n = bus.imem_resp_valid ? S_FETCH : S_DRAIN;
      end else begin
         unique case (state)
            S_FETCH: begin
               if (req_valid && bus.imem_req_ready) begin
                  req_pc_n = pc;
                  state_n  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.imem_resp_valid) begin
                  id_valid_n = 1'b1;
                  id_pc_n    = req_pc;
                  id_instr_n = bus.imem_resp_data;
                  pc_n       = req_pc + 64'd4;
                  state_n    = S_FETCH;
               end
            end
            S_DRAIN: begin
               if (bus.imem_resp_valid)
                  state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= align(RESET_PC);
         req_pc   <= '0;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_instr <= NOP;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         req_pc   <= req_pc_n;
         id_valid <= id_valid_n;
         id_pc    <= id_pc_n;
         id_instr <= id_instr_n;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector
// table, reset corner cases and randomized model check.
module tb_instruction_fetch_stage;
   import instruction_fetch_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_stage_if bus ();
   instruction_fetch_stage_if bus1 ();

   instruction_fetch_stage #(.RESET_PC(64'h0)) dut0 (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   instruction_fetch_stage #(
      .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
   ) dut1 (
      .clk   (clk),
      .reset (rst),
      .bus   (bus1)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rdy;
      logic        rsp;
      logic [31:0] dat;
      logic        red;
      logic [63:0] rpc;
      logic        idr;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_idv;
      logic [63:0] e_pc;
      logic [31:0] e_ins;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t mk(
      input logic rdy, input logic rsp, input logic [31:0] dat,
      input logic red, input logic [63:0] rpc, input logic idr,
      input logic e_req, input logic [63:0] e_addr,
      input logic e_idv, input logic [63:0] e_pc,
      input logic [31:0] e_ins);
      vec_t v;
      v.rdy = rdy; v.rsp = rsp; v.dat = dat;
      v.red = red; v.rpc = rpc; v.idr = idr;
      v.e_req = e_req; v.e_addr = e_addr;
      v.e_idv = e_idv; v.e_pc = e_pc; v.e_ins = e_ins;
      return v;
   endfunction

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rdy, input logic rsp,
                        input logic [31:0] dat, input logic red,
                        input logic [63:0] rpc, input logic idr);
      bus.imem_req_ready  = rdy;
      bus.imem_resp_valid = rsp;
      bus.imem_resp_data  = dat;
      bus.redirect_valid  = red;
      bus.redirect_pc     = rpc;
      bus.id_ready        = idr;
   endtask

   task automatic idle1();
      bus1.imem_req_ready  = 1'b0;
      bus1.imem_resp_valid = 1'b0;
      bus1.imem_resp_data  = '0;
      bus1.redirect_valid  = 1'b0;
      bus1.redirect_pc     = '0;
      bus1.id_ready        = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Entered and left just after a rising edge.
   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      idle1();
      @(negedge clk);
      chk("rst_req", {63'd0, bus.imem_req_valid}, 64'd0);
      chk("rst_idv", {63'd0, bus.id_valid}, 64'd0);
      chk("rst_idpc", bus.id_pc, 64'd0);
      chk("rst_ins", {32'd0, bus.id_instruction}, {32'd0, NOP});
      chk("rst_req1", {63'd0, bus1.imem_req_valid}, 64'd0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      string s;
      drive(v.rdy, v.rsp, v.dat, v.red, v.rpc, v.idr);
      @(negedge clk);
      s = $sformatf("vec%0d", idx);
      chk({s, "_req"}, {63'd0, bus.imem_req_valid}, {63'd0, v.e_req});
      if (v.e_req)
         chk({s, "_addr"}, bus.imem_addr, v.e_addr);
      chk({s, "_idv"}, {63'd0, bus.id_valid}, {63'd0, v.e_idv});
      if (v.e_idv) begin
         chk({s, "_idpc"}, bus.id_pc, v.e_pc);
         chk({s, "_ins"}, {32'd0, bus.id_instruction}, {32'd0, v.e_ins});
      end
      next_cycle();
   endtask

   // Randomized run against a transaction-level model.
   task automatic random_run(input int cycles);
      logic [63:0] m_pc = 64'h0;
      logic [63:0] m_req_pc = 64'h0;
      logic        m_busy = 1'b0, m_stale = 1'b0;
      logic        m_sv = 1'b0;
      logic [63:0] m_spc = 64'h0;
      logic [31:0] m_sins = 32'h0;
      logic        pend = 1'b0;
      int          dly = 0;
      logic [63:0] paddr = 64'h0;
      for (int c = 0; c < cycles; c++) begin
         logic rsp, rdy, red, idr, e_req;
         logic [31:0] dat;
         logic [63:0] rpc, cur_pc;
         rsp = pend && (dly == 0);
         if (pend && dly != 0) dly--;
         rdy = ($urandom % 4) != 0;
         red = ($urandom % 12) == 0;
         idr = ($urandom % 4) != 0;
         rpc = {$urandom, $urandom};
         if ($urandom % 3 == 0)
            rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
         dat = rsp ? word(paddr) : $urandom;
         e_req = !m_busy && !red && (!m_sv || idr);
         cur_pc = m_pc;
         drive(rdy, rsp, dat, red, rpc, idr);
         @(negedge clk);
         chk("rnd_req", {63'd0, bus.imem_req_valid}, {63'd0, e_req});
         if (e_req)
            chk("rnd_addr", bus.imem_addr, m_pc);
         chk("rnd_idv", {63'd0, bus.id_valid}, {63'd0, m_sv});
         if (m_sv) begin
            chk("rnd_idpc", bus.id_pc, m_spc);
            chk("rnd_ins", {32'd0, bus.id_instruction}, {32'd0, m_sins});
         end
         if (rsp) pend = 1'b0;
         if (e_req && rdy) begin
            pend = 1'b1;
            paddr = cur_pc;
            dly = $urandom_range(0, 2);
         end
         if (red) begin
            m_pc = {rpc[63:2], 2'b00};
            m_sv = 1'b0;
            if (m_busy) begin
               if (rsp) begin
                  m_busy = 1'b0;
                  m_stale = 1'b0;
               end else begin
                  m_stale = 1'b1;
               end
            end
         end else begin
            if (m_sv && idr) m_sv = 1'b0;
            if (m_busy && rsp) begin
               if (!m_stale) begin
                  m_sv = 1'b1;
                  m_spc = m_req_pc;
                  m_sins = dat;
                  m_pc = m_req_pc + 64'd4;
               end
               m_busy = 1'b0;
               m_stale = 1'b0;
            end else if (e_req && rdy) begin
               m_busy = 1'b1;
               m_req_pc = m_pc;
            end
         end
         next_cycle();
      end
   endtask

   initial begin
      logic [63:0] q1[$];
      logic        p1, p1n;
      logic [63:0] a1;

      drive(0, 0, 0, 0, 0, 1);
      idle1();
      next_cycle();

      tbl.push_back(mk(1,0,0,0,0,1, 1,64'h0, 0,0,0));
      tbl.push_back(mk(1,1,word(0),0,0,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0,0,1, 1,64'h4, 1,64'h0,word(0)));
      tbl.push_back(mk(1,1,word(4),0,0,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0,0,1, 1,64'h8, 1,64'h4,word(4)));
      tbl.push_back(mk(1,1,word(8),0,0,1, 0,0, 0,0,0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1,0,0,0,0,0, 0,0, 1,64'h8,word(8)));
      tbl.push_back(mk(1,0,0,0,0,1, 1,64'hC, 1,64'h8,word(8)));
      tbl.push_back(mk(1,0,0,1,64'h1002,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,1,32'hDEAD_BEEF,0,0,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0,0,1, 1,64'h1000, 0,0,0));
      tbl.push_back(mk(1,0,0,0,0,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,1,word(64'h1000),0,0,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0,0,1, 1,64'h1004,
                       1,64'h1000,word(64'h1000)));
      tbl.push_back(mk(1,1,32'hBAD0_0000,1,64'h2007,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,0,0,0,0,1, 1,64'h2004, 0,0,0));
      tbl.push_back(mk(1,1,word(64'h2004),0,0,1, 0,0, 0,0,0));
      tbl.push_back(mk(1,1,32'hFFFF_FFFF,0,0,0, 0,0,
                       1,64'h2004,word(64'h2004)));
      tbl.push_back(mk(1,0,0,1,64'h3000,0, 0,0,
                       1,64'h2004,word(64'h2004)));
      tbl.push_back(mk(1,0,0,0,0,0, 1,64'h3000, 0,0,0));
      tbl.push_back(mk(0,1,word(64'h3000),0,0,0, 0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,
                       1,64'h3000,word(64'h3000)));

      do_reset();
      foreach (tbl[i]) apply(tbl[i], i);

      // PC wrap from the top of the address space.
      do_reset();
      p1 = 1'b0;
      a1 = '0;
      bus1.imem_req_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus1.imem_resp_valid = p1;
         bus1.imem_resp_data  = word(a1);
         @(negedge clk);
         p1n = bus1.imem_req_valid && bus1.imem_req_ready;
         if (p1n) begin
            q1.push_back(bus1.imem_addr);
            a1 = bus1.imem_addr;
         end
         next_cycle();
         p1 = p1n;
      end
      idle1();
      chk("wrap_cnt", {63'd0, q1.size() >= 2}, 64'd1);
      if (q1.size() >= 2) begin
         chk("wrap_first", q1[0], 64'hFFFF_FFFF_FFFF_FFFC);
         chk("wrap_second", q1[1], 64'h0);
      end

      // Reset asserted while a request is outstanding.
      do_reset();
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mw_req", {63'd0, bus.imem_req_valid}, 64'd1);
      chk("mw_addr", bus.imem_addr, 64'h0);
      next_cycle();
      rst = 1'b1;
      drive(0, 1, 32'h1234_5678, 0, 0, 0);
      @(negedge clk);
      chk("mw_rst_req", {63'd0, bus.imem_req_valid}, 64'd0);
      chk("mw_rst_idv", {63'd0, bus.id_valid}, 64'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mw_rst_idv2", {63'd0, bus.id_valid}, 64'd0);
      next_cycle();
      rst = 1'b0;
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mw_post_req", {63'd0, bus.imem_req_valid}, 64'd1);
      chk("mw_post_addr", bus.imem_addr, 64'h0);
      chk("mw_post_idv", {63'd0, bus.id_valid}, 64'd0);
      next_cycle();
      drive(0, 1, word(0), 0, 0, 0);
      @(negedge clk);
      chk("mw_wait_req", {63'd0, bus.imem_req_valid}, 64'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mw_load_idv", {63'd0, bus.id_valid}, 64'd1);
      chk("mw_load_pc", bus.id_pc, 64'h0);
      chk("mw_load_ins", {32'd0, bus.id_instruction},
          {32'd0, word(0)});
      next_cycle();

      do_reset();
      random_run(600);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
